// File: rtl/tff_toggle_sched_if.sv
// Configuration write port for tff_toggle_sched: one channel's period and count per accepted transfer.
interface tff_toggle_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_count;

  modport master (output cfg_valid, cfg_ch, cfg_period, cfg_count, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_period, cfg_count, output cfg_ready);
endinterface

// File: rtl/tff_toggle_sched.sv
// Toggle-pulse scheduler for a bank of NCH external T flip-flops.
// Optional macro TFF_SCHED_MIRROR_EN adds q_mirror, a prediction of each TFF's state.
module tff_toggle_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  tff_toggle_sched_if.slave cfg,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   t_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   q_mirror
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         r_state [NCH];
  state_t         w_next  [NCH];
  logic [CW-1:0]  r_cfg_p [NCH];
  logic [CW-1:0]  r_cfg_n [NCH];
  logic [CW-1:0]  r_act_p [NCH];
  logic [CW-1:0]  r_act_n [NCH];
  logic [CW-1:0]  r_pcnt  [NCH];
  logic [CW-1:0]  r_ncnt  [NCH];
  logic [NCH-1:0] w_pulse;
  logic [NCH-1:0] w_last;
  logic [NCH-1:0] r_t;
  logic [NCH-1:0] r_done;
  logic           w_in_range;
  logic           w_wr;

  // Out-of-range channels are always ready so their writes drain and are dropped.
  always_comb begin
    w_in_range    = ({1'b0, cfg.cfg_ch} < (CHW+1)'(NCH));
    cfg.cfg_ready = 1'b1;
    if (w_in_range && (r_state[cfg.cfg_ch] == S_RUN))
      cfg.cfg_ready = 1'b0;
    w_wr = cfg.cfg_valid && cfg.cfg_ready && w_in_range;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) r_state[c] <= S_IDLE;
    end else begin
      for (int c = 0; c < NCH; c++) r_state[c] <= w_next[c];
    end
  end

  always_comb begin
    w_pulse = '0;
    w_last  = '0;
    for (int c = 0; c < NCH; c++) begin
      w_next[c] = r_state[c];
      case (r_state[c])
        S_IDLE: if (start[c] && !stop[c]) w_next[c] = S_RUN;
        S_RUN: begin
          if (stop[c]) begin
            w_next[c] = S_IDLE;
          end else if (r_pcnt[c] == r_act_p[c]) begin
            w_pulse[c] = 1'b1;
            if ((r_act_n[c] != '0) && (r_ncnt[c] == r_act_n[c] - ONE)) begin
              w_last[c] = 1'b1;
              w_next[c] = S_IDLE;
            end
          end
        end
        default: w_next[c] = S_IDLE;
      endcase
    end
  end

  // Stage p0 -> registered pulses, done strobes and stored configuration
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_t    <= '0;
      r_done <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_cfg_p[c] <= '0;
        r_cfg_n[c] <= '0;
      end
    end else begin
      r_t    <= w_pulse;
      r_done <= w_last;
      if (w_wr) begin
        r_cfg_p[cfg.cfg_ch] <= cfg.cfg_period;
        r_cfg_n[cfg.cfg_ch] <= cfg.cfg_count;
      end
    end
  end

  // Config is snapshotted at start so a same-cycle write only affects the next run.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if ((r_state[c] == S_IDLE) && (w_next[c] == S_RUN)) begin
        r_act_p[c] <= (r_cfg_p[c] == '0) ? ONE : r_cfg_p[c];
        r_act_n[c] <= r_cfg_n[c];
        r_pcnt[c]  <= ONE;
        r_ncnt[c]  <= '0;
      end else if (r_state[c] == S_RUN) begin
        if (w_pulse[c]) begin
          r_pcnt[c] <= ONE;
          if (r_act_n[c] != '0) r_ncnt[c] <= r_ncnt[c] + ONE;
        end else begin
          r_pcnt[c] <= r_pcnt[c] + ONE;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) busy[c] = (r_state[c] == S_RUN);
  end

  assign t_out = r_t;
  assign done  = r_done;

`ifdef TFF_SCHED_MIRROR_EN
  logic [NCH-1:0] r_qm;

  always_ff @(posedge clk) begin
    if (!rstn) r_qm <= '0;
    else       r_qm <= r_qm ^ w_pulse;
  end

  assign q_mirror = r_qm;
`else
  assign q_mirror = '0;
`endif

endmodule
